// File: rtl/bitty_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bitty_defs : shared definitions for the bitty memory arbiter.
//   - FSM state encoding (IDLE/ISSUE/WAIT/DONE, 2 bits)
//   - owner encoding (OWN_IF = 0, OWN_D = 1)
//   - default widths and the wait-counter width
// No ports; imported by the arbiter, its picker and the testbench.
// -----------------------------------------------------------------------------
package bitty_defs;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int LATENCY_DEF = 1;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/bitty_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// bitty_mem_arbiter_if : bundle of the fetch port, the load/store port and the
// single-port memory port around the bitty arbiter.
//   slave  : arbiter view (master-port requests in, memory strobes out)
//   master : environment view (core + memory), directions reversed
// Signal names keep the arbiter-relative _i/_o suffixes on both modports.
// -----------------------------------------------------------------------------
interface bitty_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = DATA_W / 8
) ();

  // fetch port
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_valid_o;
  logic              if_stall_o;
  // load/store port
  logic              d_req_i;
  logic              d_we_i;
  logic [SEL_W-1:0]  d_sel_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_valid_o;
  logic              d_stall_o;
  // memory port
  logic              mem_ce_o;
  logic              mem_we_o;
  logic [SEL_W-1:0]  mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_valid_o, if_stall_o,
    input  d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    output d_rdata_o, d_valid_o, d_stall_o,
    output mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_valid_o, if_stall_o,
    output d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    input  d_rdata_o, d_valid_o, d_stall_o,
    input  mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/bitty_mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// bitty_arb_pick : combinational 2-way picker.
//   if_elig_i / d_elig_i : eligible requests
//   last_owner_i         : previous winner (only with BITTY_ARB_RR_EN)
//   gnt_o                : some port is granted
//   owner_o              : which port is granted
// Macro BITTY_ARB_RR_EN selects round-robin; otherwise data beats fetch.
// -----------------------------------------------------------------------------
module bitty_arb_pick
  import bitty_defs::*;
(
  input  logic   if_elig_i,
  input  logic   d_elig_i,
`ifdef BITTY_ARB_RR_EN
  input  owner_e last_owner_i,
`endif
  output logic   gnt_o,
  output owner_e owner_o
);

  // grant selection
  always_comb begin
    gnt_o   = if_elig_i | d_elig_i;
    owner_o = OWN_D;
`ifdef BITTY_ARB_RR_EN
    if (if_elig_i && d_elig_i) begin
      // on contention, favour the port that lost last time
      owner_o = (last_owner_i == OWN_D) ? OWN_IF : OWN_D;
    end else if (if_elig_i) begin
      owner_o = OWN_IF;
    end else begin
      owner_o = OWN_D;
    end
`else
    // data belongs to an older instruction, so it always wins
    if (d_elig_i) begin
      owner_o = OWN_D;
    end else if (if_elig_i) begin
      owner_o = OWN_IF;
    end else begin
      owner_o = OWN_D;
    end
`endif
  end

endmodule

// File: rtl/bitty_mem_arbiter.sv
// -----------------------------------------------------------------------------
// bitty_mem_arbiter : shares one synchronous single-port memory between the
// instruction-fetch port and the load/store port.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bitty_mem_arbiter_if.slave (fetch port, data port, memory port)
// Parameters: ADDR_W, DATA_W, LATENCY (1..15), SEL_W.
// Optional macro BITTY_ARB_RR_EN: round-robin arbitration with a last-owner
// register; without it fixed data-over-fetch priority is used.
// One transaction at a time: IDLE -> ISSUE -> (WAIT ->) DONE -> IDLE.
// -----------------------------------------------------------------------------
module bitty_mem_arbiter
  import bitty_defs::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int SEL_W   = DATA_W / 8
) (
  input logic               clk,
  input logic               rst,
  bitty_mem_arbiter_if.slave bus
);

  generate
    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_lat_chk
      $fatal(1, "bitty_mem_arbiter: LATENCY must be in 1..15");
    end
  endgenerate

  // reload value for the read wait counter
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;

  logic              if_elig_s;
  logic              d_elig_s;
  logic              gnt_s;
  owner_e            pick_s;

  // a master whose valid is up this cycle has not yet dropped its request
  assign if_elig_s = bus.if_req_i & ~if_valid_q;
  assign d_elig_s  = bus.d_req_i  & ~d_valid_q;

`ifdef BITTY_ARB_RR_EN
  owner_e last_owner_q, last_owner_d;

  // last-owner register; reset value makes data win the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= OWN_IF;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

  // remember the winner of each grant
  always_comb begin
    last_owner_d = last_owner_q;
    if ((state_q == S_IDLE) && gnt_s) begin
      last_owner_d = pick_s;
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  bitty_arb_pick u_pick (
    .if_elig_i    (if_elig_s),
    .d_elig_i     (d_elig_s),
    .last_owner_i (last_owner_q),
    .gnt_o        (gnt_s),
    .owner_o      (pick_s)
  );
`else
  bitty_arb_pick u_pick (
    .if_elig_i (if_elig_s),
    .d_elig_i  (d_elig_s),
    .gnt_o     (gnt_s),
    .owner_o   (pick_s)
  );
`endif

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      owner_q    <= OWN_IF;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= {SEL_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      if_rdata_q <= {DATA_W{1'b0}};
      d_rdata_q  <= {DATA_W{1'b0}};
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
    end
  end

  // next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    ce_d       = 1'b0;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_s) begin
          state_d = S_ISSUE;
          ce_d    = 1'b1;
          owner_d = pick_s;
          if (pick_s == OWN_D) begin
            we_d    = bus.d_we_i;
            sel_d   = bus.d_sel_i;
            addr_d  = bus.d_addr_i;
            wdata_d = bus.d_wdata_i;
          end else begin
            // fetches are always full-word reads
            we_d    = 1'b0;
            sel_d   = {SEL_W{1'b1}};
            addr_d  = bus.if_addr_i;
            wdata_d = {DATA_W{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
          if (owner_q == OWN_D) begin
            d_valid_d = 1'b1;
          end else begin
            if_valid_d = 1'b1;
          end
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // counter at zero means mem_rdata_i carries this read's data now
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = S_DONE;
          if (owner_q == OWN_D) begin
            d_rdata_d = bus.mem_rdata_i;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata_i;
            if_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.if_valid_o  = if_valid_q;
  assign bus.if_stall_o  = bus.if_req_i & ~if_valid_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.d_valid_o   = d_valid_q;
  assign bus.d_stall_o   = bus.d_req_i & ~d_valid_q;
  assign bus.mem_ce_o    = ce_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_sel_o   = sel_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_bitty_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bitty_mem_arbiter : scoreboard bench for bitty_mem_arbiter.
// Master tasks push the expected completion into per-port queues; a monitor
// pops and compares on every valid pulse. Memory is modelled behaviourally
// with a LAT-deep read return pipeline; expected read data comes from a
// separate reference word array updated in data-port program order.
// -----------------------------------------------------------------------------
module tb_bitty_mem_arbiter;
  import bitty_defs::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int LAT = 4;
  localparam int RD_LAT = LAT + 2;
  localparam int WR_LAT = 2;

  typedef struct {
    logic [31:0] data;
    int          req_cyc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitty_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) bus ();

  bitty_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .SEL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference data ----------------
  logic [31:0] ref_mem [256];
  logic [31:0] d_last;
  exp_t        if_q[$];
  exp_t        d_q[$];
  int          ord[$];

  function automatic logic [31:0] init_word(int i);
    if (i == 64) return 32'h0000_0013;
    return 32'(i + 1) * 32'h9E37_79B9;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] phys [256];
  logic        written [256];
  logic [31:0] pd [LAT];
  logic        pv [LAT];

  function automatic logic [31:0] rd_word(logic [7:0] idx);
    return written[idx] ? phys[idx] : init_word(int'(idx));
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) written[i] <= 1'b0;
    end else if (bus.mem_ce_o && bus.mem_we_o) begin
      phys[bus.mem_addr_o[9:2]]    <= merge(rd_word(bus.mem_addr_o[9:2]), bus.mem_wdata_o, bus.mem_sel_o);
      written[bus.mem_addr_o[9:2]] <= 1'b1;
    end
    pv[0] <= bus.mem_ce_o & ~bus.mem_we_o;
    pd[0] <= rd_word(bus.mem_addr_o[9:2]);
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end

  // junk outside the valid return cycle exposes early or late capture
  assign bus.mem_rdata_i = pv[LAT-1] ? pd[LAT-1] : 32'hA5A5_5A5A;

  // ---------------- monitor ----------------
  int          ce_cnt = 0;
  int          done_cnt = 0;
  int          total_valid = 0;
  int          if_done_cyc = 0;
  int          d_done_cyc = 0;
  logic        prev_ce = 1'b0;
  logic        last_we;
  logic [3:0]  last_sel;
  logic [31:0] last_addr;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.if_valid_o || bus.d_valid_o) total_valid++;
      if (rst) begin
        ce_cnt   = 0;
        done_cnt = 0;
        prev_ce  = 1'b0;
      end else begin
        chk("if_stall", {63'd0, bus.if_stall_o}, {63'd0, bus.if_req_i & ~bus.if_valid_o});
        chk("d_stall", {63'd0, bus.d_stall_o}, {63'd0, bus.d_req_i & ~bus.d_valid_o});
        if (bus.mem_ce_o) begin
          chk("ce_spacing", {63'd0, prev_ce}, 64'd0);
          ce_cnt++;
          last_we   = bus.mem_we_o;
          last_sel  = bus.mem_sel_o;
          last_addr = bus.mem_addr_o;
        end
        prev_ce = bus.mem_ce_o;
        if (bus.if_valid_o) begin
          done_cnt++;
          if_done_cyc = cyc;
          ord.push_back(0);
          if (if_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_if_valid: got valid at cycle %0d, expected none", cyc);
          end else begin
            e = if_q.pop_front();
            chk("if_rdata", {32'd0, bus.if_rdata_o}, {32'd0, e.data});
            if (e.lat >= 0) chk("if_latency", 64'(cyc - e.req_cyc), 64'(e.lat));
          end
        end
        if (bus.d_valid_o) begin
          done_cnt++;
          d_done_cyc = cyc;
          ord.push_back(1);
          if (d_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_d_valid: got valid at cycle %0d, expected none", cyc);
          end else begin
            e = d_q.pop_front();
            chk("d_rdata", {32'd0, bus.d_rdata_o}, {32'd0, e.data});
            if (e.lat >= 0) chk("d_latency", 64'(cyc - e.req_cyc), 64'(e.lat));
          end
        end
        if (bus.if_valid_o || bus.d_valid_o) chk("ce_per_txn", 64'(ce_cnt), 64'(done_cnt));
      end
    end
  end

  // ---------------- master tasks (called #1 after a posedge) ----------------
  task automatic do_fetch(input logic [31:0] a, input int lat);
    exp_t e;
    int   n;
    e.data = ref_mem[a[9:2]]; e.req_cyc = cyc; e.lat = lat;
    if_q.push_back(e);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.if_valid_o && n < 200);
    if (!bus.if_valid_o) begin
      n_chk++; n_fail++;
      $display("FAIL if_timeout: got no valid after %0d cycles, expected one", n);
    end
    @(posedge clk); #1;
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = $urandom;
  endtask

  task automatic do_data(input logic we, input logic [3:0] sel, input logic [31:0] a,
                         input logic [31:0] wd, input int lat);
    exp_t e;
    int   n;
    if (we) begin
      e.data = d_last;
      ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], wd, sel);
    end else begin
      e.data = ref_mem[a[9:2]];
      d_last = e.data;
    end
    e.req_cyc = cyc; e.lat = lat;
    d_q.push_back(e);
    bus.d_req_i = 1'b1; bus.d_we_i = we; bus.d_sel_i = sel;
    bus.d_addr_i = a; bus.d_wdata_i = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.d_valid_o && n < 200);
    if (!bus.d_valid_o) begin
      n_chk++; n_fail++;
      $display("FAIL d_timeout: got no valid after %0d cycles, expected one", n);
    end
    @(posedge clk); #1;
    bus.d_req_i = 1'b0; bus.d_we_i = $urandom; bus.d_addr_i = $urandom;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_if_rdata"}, {32'd0, bus.if_rdata_o}, 64'd0);
    chk({tag, "_d_rdata"}, {32'd0, bus.d_rdata_o}, 64'd0);
    chk({tag, "_valids"}, {62'd0, bus.if_valid_o, bus.d_valid_o}, 64'd0);
    chk({tag, "_stalls"}, {62'd0, bus.if_stall_o, bus.d_stall_o}, 64'd0);
    chk({tag, "_mem_ctl"}, {58'd0, bus.mem_ce_o, bus.mem_we_o, bus.mem_sel_o}, 64'd0);
    chk({tag, "_mem_addr"}, {32'd0, bus.mem_addr_o}, 64'd0);
    chk({tag, "_mem_wdata"}, {32'd0, bus.mem_wdata_o}, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    d_last = 32'd0;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    int v0;
    rst = 1'b1; mem_clr = 1'b1; d_last = 32'd0;
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'd0;
    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_sel_i = 4'd0;
    bus.d_addr_i = 32'd0; bus.d_wdata_i = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    mem_clr = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single fetch from 0x100
    do_fetch(32'h100, RD_LAT);

    // simultaneous fetch and data read: data first, fetch at the next IDLE
    fork
      do_data(1'b0, 4'hF, 32'h200, 32'd0, RD_LAT);
      do_fetch(32'h004, -1);
    join
    chk("fetch_after_data", 64'(if_done_cyc - d_done_cyc), 64'(LAT + 3));

    // partial write, then read back the merged word
    do_data(1'b1, 4'b0011, 32'h300, 32'hDEAD_BEEF, WR_LAT);
    chk("wr_mem_we", {63'd0, last_we}, 64'd1);
    chk("wr_mem_sel", {60'd0, last_sel}, 64'h3);
    chk("wr_mem_addr", {32'd0, last_addr}, 64'h300);
    do_data(1'b0, 4'hF, 32'h300, 32'd0, RD_LAT);

    // randomized traffic: fetches in 0x000-0x0FC, data in 0x200-0x3FC
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_fetch({22'd0, 2'b00, 6'($urandom_range(0, 63)), 2'b00}, RD_LAT);
        1: do_data(1'b0, 4'hF, {22'd0, 1'b1, 7'($urandom_range(0, 127)), 2'b00}, 32'd0, RD_LAT);
        2: do_data(1'b1, 4'($urandom), {22'd0, 1'b1, 7'($urandom_range(0, 127)), 2'b00}, $urandom, WR_LAT);
        default: begin
          fork
            do_fetch({22'd0, 2'b00, 6'($urandom_range(0, 63)), 2'b00}, -1);
`ifdef BITTY_ARB_RR_EN
            do_data(1'b0, 4'hF, {22'd0, 1'b1, 7'($urandom_range(0, 127)), 2'b00}, 32'd0, -1);
`else
            do_data(1'b0, 4'hF, {22'd0, 1'b1, 7'($urandom_range(0, 127)), 2'b00}, 32'd0, RD_LAT);
`endif
          join
`ifndef BITTY_ARB_RR_EN
          chk("rand_fetch_after_data", 64'(if_done_cyc - d_done_cyc), 64'(LAT + 3));
`endif
        end
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // reset during WAIT: outputs clear at once, no valid afterwards
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_sel_i = 4'hF; bus.d_addr_i = 32'h204;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.d_req_i = 1'b0;
    #1 check_zero("midrst");
    v0 = total_valid;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    d_last = 32'd0;
    repeat (12) @(posedge clk);
    #1 chk("no_valid_after_rst", 64'(total_valid - v0), 64'd0);

`ifdef BITTY_ARB_RR_EN
    // both ports requesting back to back: grants alternate D, IF, D, IF
    do_reset();
    ord.delete();
    fork
      for (int k = 0; k < 3; k++) do_data(1'b0, 4'hF, 32'h200 + 32'(k * 4), 32'd0, -1);
      for (int k = 0; k < 3; k++) do_fetch(32'h040 + 32'(k * 4), -1);
    join
    chk("rr_count", 64'(ord.size()), 64'd6);
    for (int k = 0; k < ord.size(); k++) chk("rr_order", 64'(ord[k]), 64'((k % 2 == 0) ? 1 : 0));
`endif

    repeat (4) @(posedge clk);
    chk("if_queue_empty", 64'(if_q.size()), 64'd0);
    chk("d_queue_empty", 64'(d_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
